// File: rtl/countdown_ticker.sv
// Countdown timer with a tick/tock metronome whose silent gaps shrink as the deadline nears.
// states: IDLE stopped | TICK high tone | GAP1 silence | TOCK low tone | GAP2 silence
`timescale 1ns/1ps
module countdown_ticker #(
  parameter int CLK_HZ     = 100000000,
  parameter int TIME_W     = 7,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2,
  parameter int CHIME_CYC  = 5000000,
  parameter int TICK_HALF  = 31250,
  parameter int TOCK_HALF  = 62500,
  parameter logic [NUM_STAGES*32-1:0] GAP_TABLE =
    {32'd10000000, 32'd40000000, 32'd70000000, 32'd100000000}
) (
  input  logic              basys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [TIME_W-1:0] duration,
  input  logic              mute,
  output logic              audio_out,
  output logic              playing,
  output logic              done,
  output logic [TIME_W-1:0] secs_left,
  output logic [STAGE_W-1:0] stage
);

  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(CLK_HZ - 1);
  localparam logic [31:0]      CHIME_LAST = 32'(CHIME_CYC - 1);
  localparam logic [31:0]      TICK_LAST  = 32'(TICK_HALF - 1);
  localparam logic [31:0]      TOCK_LAST  = 32'(TOCK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TICK,
    S_GAP1,
    S_TOCK,
    S_GAP2
  } beat_t;

  beat_t              state, state_nxt;
  logic [31:0]        phase, phase_nxt;
  logic [31:0]        tone_cnt, tone_nxt;
  logic               tone_lvl, lvl_nxt;
  logic [31:0]        half_last;
  logic [SEC_W-1:0]   sec_cnt;
  logic [TIME_W-1:0]  thr [NUM_STAGES];
  logic [31:0]        q_full;
  logic [STAGE_W-1:0] stage_sel;
  logic               stage_hit;
  logic [31:0]        gap_cur;
  logic               gap_done;
  logic               start_ok;
  logic               abort_now;
  logic               sec_wrap;
  logic               expire;

  assign start_ok  = start & ~playing & ~abort & (duration != '0);
  assign abort_now = abort & playing;
  assign sec_wrap  = playing & (sec_cnt == SEC_LAST);
  assign expire    = sec_wrap & (secs_left == TIME_W'(1)) & ~abort;
  assign q_full    = 32'(duration) / 32'(NUM_STAGES);

  // Thresholds are (NUM_STAGES-1-k)*Q, latched once at start; the constant
  // factors keep the per-cycle path to a compare chain.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      playing   <= 1'b0;
      done      <= 1'b0;
      secs_left <= '0;
      sec_cnt   <= '0;
      for (int k = 0; k < NUM_STAGES; k++) thr[k] <= '0;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        playing   <= 1'b0;
        secs_left <= '0;
        sec_cnt   <= '0;
      end else if (start_ok) begin
        playing   <= 1'b1;
        secs_left <= duration;
        sec_cnt   <= '0;
        for (int k = 0; k < NUM_STAGES; k++)
          thr[k] <= TIME_W'(q_full * 32'(NUM_STAGES - 1 - k));
      end else if (playing) begin
        if (sec_wrap) begin
          sec_cnt   <= '0;
          secs_left <= secs_left - TIME_W'(1);
          if (secs_left == TIME_W'(1)) begin
            playing <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          sec_cnt <= sec_cnt + SEC_W'(1);
        end
      end
    end
  end

  always_comb begin
    stage_sel = '0;
    stage_hit = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!stage_hit && (secs_left > thr[k])) begin
        stage_sel = STAGE_W'(k);
        stage_hit = 1'b1;
      end
    end
  end

  assign stage    = stage_sel;
  assign gap_cur  = GAP_TABLE[int'(stage_sel)*32 +: 32];
  assign gap_done = ({1'b0, phase} + 33'd1) >= {1'b0, gap_cur};

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + 32'd1;
    tone_nxt  = tone_cnt;
    lvl_nxt   = tone_lvl;
    half_last = (state == S_TOCK) ? TOCK_LAST : TICK_LAST;
    if (abort_now || expire) begin
      state_nxt = S_IDLE;
      phase_nxt = '0;
      tone_nxt  = '0;
      lvl_nxt   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          phase_nxt = '0;
          tone_nxt  = '0;
          lvl_nxt   = 1'b0;
          if (start_ok) begin
            state_nxt = S_TICK;
            lvl_nxt   = 1'b1;
          end
        end
        S_TICK, S_TOCK: begin
          if (phase == CHIME_LAST) begin
            state_nxt = (state == S_TICK) ? S_GAP1 : S_GAP2;
            phase_nxt = '0;
            tone_nxt  = '0;
            lvl_nxt   = 1'b0;
          end else if (tone_cnt == half_last) begin
            tone_nxt = '0;
            lvl_nxt  = ~tone_lvl;
          end else begin
            tone_nxt = tone_cnt + 32'd1;
          end
        end
        S_GAP1, S_GAP2: begin
          if (gap_done) begin
            state_nxt = (state == S_GAP1) ? S_TOCK : S_TICK;
            phase_nxt = '0;
            tone_nxt  = '0;
            lvl_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          phase_nxt = '0;
          tone_nxt  = '0;
          lvl_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Mute only gates the registered pin; the tone generator keeps running.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      tone_cnt  <= '0;
      tone_lvl  <= 1'b0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      tone_cnt  <= tone_nxt;
      tone_lvl  <= lvl_nxt;
      audio_out <= lvl_nxt & ~mute;
    end
  end

endmodule

// File: tb/tb_countdown_ticker.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_countdown_ticker;

  localparam int TIME_W  = 7;
  localparam int STAGE_W = 2;
  localparam int SIG_AUD = 0, SIG_PLAY = 1, SIG_DONE = 2, SIG_SECS = 3, SIG_STAGE = 4;

  logic              basys_clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [TIME_W-1:0] duration;
  logic              mute;
  logic              audio_out;
  logic              playing;
  logic              done;
  logic [TIME_W-1:0] secs_left;
  logic [STAGE_W-1:0] stage;

  countdown_ticker #(
    .CLK_HZ(100), .TIME_W(TIME_W), .NUM_STAGES(4), .STAGE_W(STAGE_W),
    .CHIME_CYC(5), .TICK_HALF(2), .TOCK_HALF(4),
    .GAP_TABLE({32'd10, 32'd20, 32'd30, 32'd40})
  ) dut (
    .basys_clk(basys_clk), .reset(reset), .start(start), .abort(abort),
    .duration(duration), .mute(mute), .audio_out(audio_out), .playing(playing),
    .done(done), .secs_left(secs_left), .stage(stage)
  );

  always #5 basys_clk = ~basys_clk;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   p;
  exp_t mon_e;
  int   mon_act;
  int   mon_c;

  always @(posedge basys_clk) cyc <= cyc + 1;

  function automatic int sample(input int sig);
    case (sig)
      SIG_AUD:   return int'(audio_out);
      SIG_PLAY:  return int'(playing);
      SIG_DONE:  return int'(done);
      SIG_SECS:  return int'(secs_left);
      default:   return int'(stage);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_AUD:   return "audio_out";
      SIG_PLAY:  return "playing";
      SIG_DONE:  return "done";
      SIG_SECS:  return "secs_left";
      default:   return "stage";
    endcase
  endfunction

  task automatic push(input int c, input int sig, input int val);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = sig; e.val = val;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endtask

  always @(negedge basys_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = sample(mon_e.sig);
      n_chk++;
      if (mon_e.cyc == cyc && mon_act == mon_e.val) n_pass++;
      else $display("FAIL %s @cycle %0d (checked at %0d): got %0d, expected %0d",
                    sig_name(mon_e.sig), mon_e.cyc, cyc, mon_act, mon_e.val);
    end
    if (done) begin
      n_chk++;
      if (done_q.size() == 0) begin
        $display("FAIL done_pulse: unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (mon_c == cyc) n_pass++;
        else $display("FAIL done_pulse: got pulse at cycle %0d, expected at %0d", cyc, mon_c);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge basys_clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // Raise start for the current cycle; p is the cycle playing should rise.
  task automatic kick(input int dur);
    start    = 1'b1;
    duration = TIME_W'(dur);
    p        = cyc + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int st8[8]   = '{0, 0, 1, 1, 2, 2, 3, 3};
  int tick5[5] = '{1, 1, 0, 0, 1};
  int tock5[5] = '{1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; duration = '0; mute = 1'b0;
    step(1);
    push(cyc, SIG_AUD, 0); push(cyc, SIG_PLAY, 0); push(cyc, SIG_DONE, 0);
    push(cyc, SIG_SECS, 0); push(cyc, SIG_STAGE, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // duration 8: stage ladder, beat pattern, done after 800 cycles
    kick(8);
    push(p - 1, SIG_PLAY, 0); push(p, SIG_PLAY, 1);
    for (int i = 0; i < 8; i++) begin
      push(p + 100*i, SIG_SECS, 8 - i);
      push(p + 100*i + 99, SIG_SECS, 8 - i);
      push(p + 100*i, SIG_STAGE, st8[i]);
      push(p + 100*i + 99, SIG_STAGE, st8[i]);
    end
    for (int i = 0; i < 5; i++) begin
      push(p + i, SIG_AUD, tick5[i]);
      push(p + 45 + i, SIG_AUD, tock5[i]);
    end
    push(p + 5, SIG_AUD, 0);   push(p + 44, SIG_AUD, 0);
    push(p + 50, SIG_AUD, 0);  push(p + 89, SIG_AUD, 0);
    push(p + 90, SIG_AUD, 1);
    push(p + 214, SIG_AUD, 0); push(p + 215, SIG_AUD, 1);
    push(p + 249, SIG_AUD, 0); push(p + 250, SIG_AUD, 1);
    done_q.push_back(p + 800);
    push(p + 799, SIG_PLAY, 1);
    push(p + 800, SIG_PLAY, 0); push(p + 800, SIG_SECS, 0);
    push(p + 800, SIG_STAGE, 0); push(p + 800, SIG_AUD, 0);
    push(p + 801, SIG_DONE, 0);
    step(1);
    start = 1'b0;
    wait_until(p + 10);
    start = 1'b1; duration = TIME_W'(5);
    step(1);
    start = 1'b0;
    wait_until(p + 805);

    // duration 0 is ignored
    kick(0);
    push(p, SIG_PLAY, 0);
    step(1);
    start = 1'b0;
    step(2);

    // duration 3: Q=0 keeps stage 0
    kick(3);
    push(p, SIG_PLAY, 1); push(p, SIG_SECS, 3);
    push(p, SIG_STAGE, 0); push(p + 150, SIG_STAGE, 0); push(p + 299, SIG_STAGE, 0);
    push(p + 299, SIG_SECS, 1);
    done_q.push_back(p + 300);
    push(p + 300, SIG_PLAY, 0);
    step(1);
    start = 1'b0;
    wait_until(p + 305);

    // abort at cycle 250 of an 8 s run
    kick(8);
    push(p, SIG_PLAY, 1);
    step(1);
    start = 1'b0;
    wait_until(p + 250);
    push(p + 250, SIG_PLAY, 1); push(p + 250, SIG_SECS, 6); push(p + 250, SIG_STAGE, 1);
    push(p + 251, SIG_PLAY, 0); push(p + 251, SIG_SECS, 0);
    push(p + 251, SIG_STAGE, 0); push(p + 251, SIG_AUD, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);

    // abort and start together while idle: abort wins
    abort = 1'b1; start = 1'b1; duration = TIME_W'(5);
    push(cyc + 1, SIG_PLAY, 0);
    step(1);
    abort = 1'b0; start = 1'b0;
    step(2);

    // abort on the expiry cycle: no done pulse
    kick(1);
    push(p, SIG_PLAY, 1);
    step(1);
    start = 1'b0;
    wait_until(p + 99);
    push(p + 99, SIG_SECS, 1);
    push(p + 100, SIG_PLAY, 0); push(p + 100, SIG_SECS, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(5);

    // mute for a whole 2 s run
    mute = 1'b1;
    kick(2);
    push(p, SIG_PLAY, 1);
    push(p, SIG_AUD, 0); push(p + 1, SIG_AUD, 0); push(p + 45, SIG_AUD, 0);
    push(p + 46, SIG_AUD, 0); push(p + 90, SIG_AUD, 0);
    push(p + 100, SIG_SECS, 1);
    done_q.push_back(p + 200);
    push(p + 200, SIG_PLAY, 0);
    step(1);
    start = 1'b0;
    wait_until(p + 205);
    mute = 1'b0;

    // reset mid-TOCK clears outputs before the next clock edge
    kick(8);
    push(p + 45, SIG_AUD, 1);
    step(1);
    start = 1'b0;
    wait_until(p + 46);
    reset = 1'b1;
    push(cyc, SIG_AUD, 0); push(cyc, SIG_PLAY, 0); push(cyc, SIG_SECS, 0);
    push(cyc, SIG_STAGE, 0); push(cyc, SIG_DONE, 0);
    step(3);
    reset = 1'b0;
    step(2);
    kick(1);
    push(p, SIG_PLAY, 1); push(p, SIG_AUD, 1); push(p, SIG_SECS, 1);
    done_q.push_back(p + 100);
    push(p + 100, SIG_PLAY, 0);
    step(1);
    start = 1'b0;
    wait_until(p + 105);

    step(3);
    n_chk++;
    if (done_q.size() == 0) n_pass++;
    else $display("FAIL done_pending: %0d expected pulses never seen, expected 0", done_q.size());
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL exp_pending: %0d expectations unchecked, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
